// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM demultiplexer: a serial stream of alternating WIDTH-bit
// A/B words, aligned by a sync marker on the A-word MSB, is presented as
// parallel a/b words once per frame, with frame-lock tracking and a
// sync-violation pulse.
module tdm_demux_2ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             v,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             o_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT,
        RX_A,
        RX_B
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] sh_a, sh_a_nx;
    logic [WIDTH-1:0] sh_b, sh_b_nx;
    logic [WIDTH-1:0] a_nx, b_nx;
    logic             o_valid_nx, locked_nx, sync_err_nx;

    // A sync-marked bit always restarts the A word with that bit as its MSB.
    logic [WIDTH-1:0] a_restart;
    assign a_restart = {{(WIDTH-1){1'b0}}, d};

    // Next-state and next-output decode; only strobed bits move the frame.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case leaves one unassigned, which would infer a latch.
        state_nx    = state;
        cnt_nx      = cnt;
        sh_a_nx     = sh_a;
        sh_b_nx     = sh_b;
        a_nx        = a;
        b_nx        = b;
        locked_nx   = locked;
        o_valid_nx  = 1'b0;
        sync_err_nx = 1'b0;

        if (v) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        sh_a_nx   = a_restart;
                        cnt_nx    = CW'(1);
                        state_nx  = RX_A;
                        locked_nx = 1'b1;
                    end
                end

                RX_A: begin
                    if (cnt == '0 && !sync) begin
                        // Expected frame start did not carry sync: lock lost.
                        sync_err_nx = 1'b1;
                        locked_nx   = 1'b0;
                        state_nx    = HUNT;
                        cnt_nx      = '0;
                    end else if (cnt != '0 && sync) begin
                        // Early sync: drop the partial frame and realign here.
                        sync_err_nx = 1'b1;
                        sh_a_nx     = a_restart;
                        cnt_nx      = CW'(1);
                    end else begin
                        sh_a_nx = {sh_a[WIDTH-2:0], d};
                        if (cnt == LAST) begin
                            state_nx = RX_B;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end

                RX_B: begin
                    if (sync) begin
                        sync_err_nx = 1'b1;
                        sh_a_nx     = a_restart;
                        cnt_nx      = CW'(1);
                        state_nx    = RX_A;
                    end else begin
                        sh_b_nx = {sh_b[WIDTH-2:0], d};
                        if (cnt == LAST) begin
                            a_nx       = sh_a;
                            b_nx       = {sh_b[WIDTH-2:0], d};
                            o_valid_nx = 1'b1;
                            state_nx   = RX_A;
                            cnt_nx     = '0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    state_nx = HUNT;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State and registered outputs; reset discards any partial frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are reset along with the control
            // state so a frame interrupted by reset can never leak stale bits.
            state    <= HUNT;
            cnt      <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            a        <= '0;
            b        <= '0;
            o_valid  <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state    <= state_nx;
            cnt      <= cnt_nx;
            sh_a     <= sh_a_nx;
            sh_b     <= sh_b_nx;
            a        <= a_nx;
            b        <= b_nx;
            o_valid  <= o_valid_nx;
            locked   <= locked_nx;
            sync_err <= sync_err_nx;
        end
    end

endmodule
